// File: rtl/stepper_pulse_gen.sv
// -----------------------------------------------------------------------------
// stepper_pulse_gen
//
// Step/dir generator for one motor axis. Register writes program a move of
// STEPS steps at a fixed step period. The block drives the step, dir and
// enable pins, tracks the absolute signed step position, and pulses done_int
// for one cycle whenever a move ends (normal completion, abort or disable).
//
// Register map (written when reg_stb is high):
//   0 PERIOD   cycles between step rising edges; clamped to >= 2*STEP_WIDTH
//   1 STEPS    move length (ignored while busy)
//   2 CONTROL  bit0 dir, bit1 en, bit2 start, bit3 abort (start/abort are strobes)
//   3 POSITION load absolute position (ignored while busy)
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   reg_addr    register select
//   reg_data    write data
//   reg_stb     one-cycle write strobe
//   busy        move in progress (high from start until the done cycle inclusive)
//   done_int    one-cycle pulse at the end of every move
//   position    signed absolute step position
//   mot_step    step pin, active high
//   mot_dir     direction pin, 1 = positive
//   mot_enable  driver enable, active low
//   dbg_state   current FSM state, for observation only
//
// Handshake: there is no back-pressure. A write is accepted on every clk edge
// where reg_stb is high; writes the current state cannot honour are dropped.
// -----------------------------------------------------------------------------
module stepper_pulse_gen #(
    parameter int unsigned STEP_WIDTH = 100,
    parameter int unsigned DIR_SETUP  = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  reg_addr,
    input  logic [31:0] reg_data,
    input  logic        reg_stb,
    output logic        busy,
    output logic        done_int,
    output logic [31:0] position,
    output logic        mot_step,
    output logic        mot_dir,
    output logic        mot_enable,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [31:0] MIN_PERIOD = 32'(2 * STEP_WIDTH);
    localparam logic [31:0] SW_CYCLES  = 32'(STEP_WIDTH);
    localparam logic [31:0] HIGH_LOAD  = 32'(STEP_WIDTH - 1);
    localparam logic [31:0] SETUP_LOAD = 32'(DIR_SETUP - 1);

    logic [2:0]  state_q, state_d;
    logic [31:0] period_q, period_d;
    logic [31:0] steps_q, steps_d;
    logic [31:0] position_q, position_d;
    logic [31:0] remaining_q, remaining_d;
    logic [31:0] cnt_q, cnt_d;
    logic        dir_bit_q, dir_bit_d;
    logic        en_bit_q, en_bit_d;
    logic        step_q, step_d;
    logic        dir_q, dir_d;
    logic        enable_q;
    logic        busy_q;
    logic        done_q;

    logic        wr_period, wr_steps, wr_ctrl, wr_pos;
    logic        in_move, kill, start_req;
    logic [31:0] eff_period;

    always_comb begin
        wr_period = reg_stb && (reg_addr == 2'd0);
        wr_steps  = reg_stb && (reg_addr == 2'd1);
        wr_ctrl   = reg_stb && (reg_addr == 2'd2);
        wr_pos    = reg_stb && (reg_addr == 2'd3);
        in_move   = (state_q != S_IDLE);

        period_d = wr_period ? reg_data : period_q;
        steps_d  = (wr_steps && !in_move) ? reg_data : steps_q;

        en_bit_d  = wr_ctrl ? reg_data[1] : en_bit_q;
        dir_bit_d = (wr_ctrl && !in_move) ? reg_data[0] : dir_bit_q;

        // Abort, or dropping enable, ends an active move. The DONE cycle is
        // already ending, so nothing extra happens there.
        kill      = in_move && (state_q != S_DONE) && wr_ctrl && (reg_data[3] || !reg_data[1]);
        // Abort in the same write suppresses start.
        start_req = !in_move && wr_ctrl && reg_data[2] && !reg_data[3];

        // Uses period_d so a PERIOD write in the LOW-entry cycle applies at once.
        eff_period = (period_d > MIN_PERIOD) ? period_d : MIN_PERIOD;

        state_d     = state_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        dir_d       = dir_q;
        remaining_d = remaining_q;
        position_d  = (wr_pos && !in_move) ? reg_data : position_q;

        if (kill) begin
            state_d = S_DONE;
            step_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_req) begin
                        if (en_bit_d && (steps_q != 32'd0)) begin
                            remaining_d = steps_q;
                            dir_d       = dir_bit_d;
                            cnt_d       = SETUP_LOAD;
                            state_d     = S_SETUP;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_SETUP, S_LOW: begin
                    if (cnt_q != 32'd0) begin
                        cnt_d = cnt_q - 32'd1;
                    end else if ((state_q == S_LOW) && (remaining_q == 32'd0)) begin
                        state_d = S_DONE;
                    end else begin
                        // Rising edge: the step is counted the moment it starts.
                        state_d     = S_HIGH;
                        step_d      = 1'b1;
                        cnt_d       = HIGH_LOAD;
                        remaining_d = remaining_q - 32'd1;
                        position_d  = position_q + (dir_q ? 32'd1 : 32'hFFFF_FFFF);
                    end
                end
                S_HIGH: begin
                    if (cnt_q != 32'd0) begin
                        cnt_d = cnt_q - 32'd1;
                    end else begin
                        state_d = S_LOW;
                        step_d  = 1'b0;
                        // Low time makes the rise-to-rise spacing eff_period.
                        cnt_d   = eff_period - SW_CYCLES - 32'd1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    step_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            period_q    <= 32'd0;
            steps_q     <= 32'd0;
            position_q  <= 32'd0;
            remaining_q <= 32'd0;
            cnt_q       <= 32'd0;
            dir_bit_q   <= 1'b0;
            en_bit_q    <= 1'b0;
            step_q      <= 1'b0;
            dir_q       <= 1'b0;
            enable_q    <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            steps_q     <= steps_d;
            position_q  <= position_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            dir_bit_q   <= dir_bit_d;
            en_bit_q    <= en_bit_d;
            step_q      <= step_d;
            dir_q       <= dir_d;
            enable_q    <= ~en_bit_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign busy       = busy_q;
    assign done_int   = done_q;
    assign position   = position_q;
    assign mot_step   = step_q;
    assign mot_dir    = dir_q;
    assign mot_enable = enable_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_stepper_pulse_gen
//
// Directed and randomized moves. For each move a reference model predicts the
// clock edge of every step rise and fall, the done pulse and the final
// position from the register writes that were actually issued (with the edge
// at which each write was sampled), and a monitor records what the pins did.
// -----------------------------------------------------------------------------
module tb_stepper_pulse_gen;

    localparam int SW = 100;
    localparam int DS = 50;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  reg_addr = 2'd0;
    logic [31:0] reg_data = 32'd0;
    logic        reg_stb = 1'b0;
    logic        busy, done_int, mot_step, mot_dir, mot_enable;
    logic [31:0] position;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    stepper_pulse_gen #(.STEP_WIDTH(SW), .DIR_SETUP(DS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .reg_stb    (reg_stb),
        .busy       (busy),
        .done_int   (done_int),
        .position   (position),
        .mot_step   (mot_step),
        .mot_dir    (mot_dir),
        .mot_enable (mot_enable),
        .dbg_state  (dbg_state)
    );

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int   act_rise[$];
    int   act_fall[$];
    int   act_done[$];
    int   act_busy[$];
    logic act_dir[$];
    int   en_low_cnt = 0;
    logic prev_step = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (mot_step && !prev_step) begin
            act_rise.push_back(cyc);
            act_dir.push_back(mot_dir);
        end
        if (!mot_step && prev_step) act_fall.push_back(cyc);
        if (done_int) begin
            act_done.push_back(cyc);
            check_eq("done_back_to_back", {31'd0, prev_done}, 32'd0);
        end
        if (busy && !prev_busy) act_busy.push_back(cyc);
        if (!mot_enable) en_low_cnt <= en_low_cnt + 1;
        prev_step <= mot_step;
        prev_busy <= busy;
        prev_done <= done_int;
    end

    // ---------------- driver ----------------
    // e returns the clock edge that samples the write.
    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d, output int e);
        @(negedge clk);
        reg_addr = a;
        reg_data = d;
        reg_stb  = 1'b1;
        e = cyc + 1;
        @(negedge clk);
        reg_stb  = 1'b0;
    endtask

    // ---------------- reference model ----------------
    int          pw_edge[$];
    logic [31:0] pw_val[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_fall_q[$];
    int          exp_done;
    int          exp_cnt;

    function automatic logic [31:0] period_at(input int e);
        logic [31:0] p = 32'd0;
        for (int i = 0; i < pw_edge.size(); i++)
            if (pw_edge[i] <= e) p = pw_val[i];
        return p;
    endfunction

    // s: start edge, a: abort/disable edge (0 = none)
    task automatic model_move(input int s, input int n, input bit ok, input int a);
        int t, le;
        logic [31:0] p;
        exp_q.delete();
        exp_fall_q.delete();
        exp_cnt = 0;
        if (!ok) begin
            exp_done = s;
            return;
        end
        t = s + DS;
        for (int k = 0; k < n; k++) begin
            if (a != 0 && a <= t) break;
            exp_q.push_back(32'(t));
            exp_cnt++;
            le = t + SW;
            if (a != 0 && a <= le) begin
                exp_fall_q.push_back(32'(a));
                t = a;
                break;
            end
            exp_fall_q.push_back(32'(le));
            p = period_at(le);
            t = t + int'((p > 32'(2 * SW)) ? p : 32'(2 * SW));
        end
        exp_done = (a != 0 && a <= t) ? a : t;
    endtask

    // ---------------- move scenario ----------------
    // ev_kind: 0 none, 1 PERIOD change, 2 abort, 3 enable cleared.
    // The event is written ev_off cycles after step ev_step rises.
    task automatic do_move(input string tag, input int n, input bit dir, input bit en,
                           input logic [31:0] pos0, input logic [31:0] per0,
                           input int ev_kind, input int ev_step, input int ev_off,
                           input logic [31:0] ev_val);
        int e, s, a, lim, br, bf, bd, bb, ben, nr, nf;
        bit ok, en_final;
        logic [31:0] exp_pos;
        a = 0;
        ok = en && (n != 0);
        en_final = en;
        pw_edge.delete();
        pw_val.delete();
        if (!en) reg_wr(2'd2, 32'd0, e);
        reg_wr(2'd3, pos0, e);
        reg_wr(2'd0, per0, e);
        pw_edge.push_back(e);
        pw_val.push_back(per0);
        reg_wr(2'd1, 32'(n), e);
        br = act_rise.size(); bf = act_fall.size(); bd = act_done.size();
        bb = act_busy.size(); ben = en_low_cnt;
        reg_wr(2'd2, {28'd0, 1'b0, 1'b1, en, dir}, s);
        if (ok) begin
            // All three are dropped while a move is running.
            reg_wr(2'd1, $urandom, e);
            reg_wr(2'd2, {28'd0, 1'b0, 1'b1, 1'b1, ~dir}, e);
            reg_wr(2'd3, $urandom, e);
            if (ev_kind != 0) begin
                lim = 0;
                while (act_rise.size() - br < ev_step && lim < 20000) begin
                    @(negedge clk);
                    lim++;
                end
                check_eq({tag, " event_wait"}, 32'(act_rise.size() - br >= ev_step), 32'd1);
                repeat (ev_off) @(negedge clk);
                case (ev_kind)
                    1: begin
                        reg_wr(2'd0, ev_val, e);
                        pw_edge.push_back(e);
                        pw_val.push_back(ev_val);
                    end
                    2: reg_wr(2'd2, {28'd0, 1'b1, 1'b0, 1'b1, dir}, a);
                    default: begin
                        reg_wr(2'd2, {28'd0, 1'b0, 1'b0, 1'b0, dir}, a);
                        en_final = 1'b0;
                    end
                endcase
            end
        end
        lim = 0;
        while (act_done.size() == bd && lim < 40000) begin
            @(negedge clk);
            lim++;
        end
        repeat (30) @(negedge clk);

        model_move(s, n, ok, a);
        exp_pos = dir ? (pos0 + 32'(exp_cnt)) : (pos0 - 32'(exp_cnt));

        check_eq({tag, " busy_rise"}, 32'((act_busy.size() > bb) ? act_busy[bb] : -1), 32'(s));
        nr = act_rise.size() - br;
        nf = act_fall.size() - bf;
        check_eq({tag, " n_rise"}, 32'(nr), 32'(exp_q.size()));
        check_eq({tag, " n_fall"}, 32'(nf), 32'(exp_fall_q.size()));
        for (int i = 0; i < nr && i < exp_q.size(); i++) begin
            check_eq({tag, $sformatf(" rise%0d", i)}, 32'(act_rise[br + i]), exp_q[i]);
            check_eq({tag, $sformatf(" dir%0d", i)}, {31'd0, act_dir[br + i]}, {31'd0, dir});
        end
        for (int i = 0; i < nf && i < exp_fall_q.size(); i++)
            check_eq({tag, $sformatf(" fall%0d", i)}, 32'(act_fall[bf + i]), exp_fall_q[i]);
        check_eq({tag, " n_done"}, 32'(act_done.size() - bd), 32'd1);
        check_eq({tag, " done_edge"}, 32'((act_done.size() > bd) ? act_done[bd] : -1), 32'(exp_done));
        check_eq({tag, " position"}, position, exp_pos);
        check_eq({tag, " busy_end"}, {31'd0, busy}, 32'd0);
        check_eq({tag, " step_end"}, {31'd0, mot_step}, 32'd0);
        check_eq({tag, " enable_end"}, {31'd0, mot_enable}, {31'd0, ~en_final});
        if (!en) check_eq({tag, " enable_never_low"}, 32'(en_low_cnt - ben), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int e, lim, br, bd, n, ev;
        repeat (3) @(negedge clk);
        check_eq("rst busy", {31'd0, busy}, 32'd0);
        check_eq("rst done", {31'd0, done_int}, 32'd0);
        check_eq("rst step", {31'd0, mot_step}, 32'd0);
        check_eq("rst dir", {31'd0, mot_dir}, 32'd0);
        check_eq("rst enable", {31'd0, mot_enable}, 32'd1);
        check_eq("rst position", position, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_move("basic3",   3, 1'b1, 1'b1, 32'd0, 32'd1000, 0, 0, 0, 32'd0);
        check_eq("basic3 pos_abs", position, 32'd3);
        do_move("clamp",    4, 1'b0, 1'b1, 32'd5, 32'd0,    0, 0, 0, 32'd0);
        check_eq("clamp pos_abs", position, 32'd1);
        do_move("zero",     0, 1'b1, 1'b1, 32'd7, 32'd300,  0, 0, 0, 32'd0);
        do_move("disabled", 2, 1'b1, 1'b0, 32'd7, 32'd300,  0, 0, 0, 32'd0);
        do_move("abort",   10, 1'b1, 1'b1, 32'd0, 32'd400,  2, 4, 20, 32'd0);
        check_eq("abort pos_abs", position, 32'd4);
        do_move("perchg",   5, 1'b1, 1'b1, 32'd0, 32'd400,  1, 2, 5, 32'd800);
        do_move("encut",    6, 1'b0, 1'b1, 32'd100, 32'd250, 3, 3, 180, 32'd0);
        do_move("wrap",     1, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'd200, 0, 0, 0, 32'd0);
        check_eq("wrap pos_abs", position, 32'h8000_0000);

        for (int i = 0; i < 6; i++) begin
            n  = $urandom_range(1, 6);
            ev = $urandom_range(0, 3);
            do_move($sformatf("rnd%0d", i), n, 1'($urandom_range(0, 1)), 1'b1, $urandom,
                    32'($urandom_range(0, 600)), ev, $urandom_range(1, n),
                    $urandom_range(0, 150), 32'($urandom_range(0, 700)));
        end

        // Reset in the middle of a move.
        reg_wr(2'd0, 32'd300, e);
        reg_wr(2'd1, 32'd5, e);
        reg_wr(2'd2, 32'd7, e);
        lim = 0;
        br = act_rise.size();
        while (act_rise.size() - br < 2 && lim < 5000) begin
            @(negedge clk);
            lim++;
        end
        check_eq("midrst wait", 32'(act_rise.size() - br >= 2), 32'd1);
        repeat (10) @(negedge clk);
        br = act_rise.size();
        bd = act_done.size();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("midrst busy", {31'd0, busy}, 32'd0);
        check_eq("midrst done", {31'd0, done_int}, 32'd0);
        check_eq("midrst step", {31'd0, mot_step}, 32'd0);
        check_eq("midrst dir", {31'd0, mot_dir}, 32'd0);
        check_eq("midrst enable", {31'd0, mot_enable}, 32'd1);
        check_eq("midrst position", position, 32'd0);
        repeat (1000) @(negedge clk);
        check_eq("midrst no_rise", 32'(act_rise.size() - br), 32'd0);
        check_eq("midrst no_done", 32'(act_done.size() - bd), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
